// File: rtl/ct_spsram_2048x59_arb_ctrl_if.sv
// ---------------------------------------------------------------------------
// ct_spsram_2048x59_arb_ctrl_if
//
// Bundle of every non-clock signal of the SRAM access controller.
//   Requester side : wr_req/wr_addr/wr_data/wr_bwen -> wr_gnt
//                    rd_req/rd_addr -> rd_gnt, rd_vld, rd_data
//                    clr_req -> init_done, busy
//   Macro side     : A, CEN, GWEN, WEN, D (to the macro), Q (from the macro)
//
// Modports:
//   slave  - the controller view (requests and Q in, grants and pins out)
//   master - the environment view (requesters plus the macro itself)
// ---------------------------------------------------------------------------
interface ct_spsram_2048x59_arb_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 59
);
  // Write requester
  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] wr_bwen;
  logic                  wr_gnt;

  // Read requester
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_gnt;
  logic                  rd_vld;
  logic [DATA_WIDTH-1:0] rd_data;

  // Clear / status
  logic                  clr_req;
  logic                  init_done;
  logic                  busy;

  // SRAM macro pins
  logic [ADDR_WIDTH-1:0] A;
  logic                  CEN;
  logic                  GWEN;
  logic [DATA_WIDTH-1:0] WEN;
  logic [DATA_WIDTH-1:0] D;
  logic [DATA_WIDTH-1:0] Q;

  modport slave (
    input  wr_req, wr_addr, wr_data, wr_bwen,
    input  rd_req, rd_addr,
    input  clr_req,
    input  Q,
    output wr_gnt, rd_gnt, rd_vld, rd_data,
    output init_done, busy,
    output A, CEN, GWEN, WEN, D
  );

  modport master (
    output wr_req, wr_addr, wr_data, wr_bwen,
    output rd_req, rd_addr,
    output clr_req,
    output Q,
    input  wr_gnt, rd_gnt, rd_vld, rd_data,
    input  init_done, busy,
    input  A, CEN, GWEN, WEN, D
  );
endinterface

// File: rtl/ct_spsram_2048x59_arb_ctrl.sv
// ---------------------------------------------------------------------------
// ct_spsram_2048x59_arb_ctrl
//
// Access controller for one 2^ADDR_WIDTH x DATA_WIDTH single-port SRAM macro
// (active-low CEN, GWEN and per-bit WEN).
//   - INIT: sweeps every address to zero, one write per cycle, requests wait.
//   - RUN : shares the port between one write and one read requester.
//           Grants are combinational in the request cycle; rd_vld follows a
//           read grant by one cycle and rd_data is the macro Q.
//   - clr_req in RUN re-enters INIT on the next cycle.
//
// Ports:
//   CLK  - clock, also the SRAM clock
//   RST  - asynchronous, active-high reset
//   bus  - requester handshakes, status and SRAM pins (slave modport)
//
// Parameters:
//   INIT_EN - 1: zero sweep after reset, 0: start in RUN
//   RD_PRIO - 0: round-robin on conflict, 1: read always wins
// ---------------------------------------------------------------------------
module ct_spsram_2048x59_arb_ctrl #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 59,
  parameter bit          INIT_EN    = 1'b1,
  parameter bit          RD_PRIO    = 1'b0
) (
  input  logic                       CLK,
  input  logic                       RST,
  ct_spsram_2048x59_arb_ctrl_if.slave bus
);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_e;

  typedef enum logic {
    WIN_WR,
    WIN_RD
  } side_e;

  localparam state_e                RESET_STATE = INIT_EN ? S_INIT : S_RUN;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = '1;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] init_cnt_q;
  side_e                 last_win_q;
  logic                  rd_vld_q;
  logic                  init_done_q;
  logic                  busy_q;

  logic in_run;
  logic conflict;
  logic wr_gnt;
  logic rd_gnt;

  // ------------------------------------------------------------------------
  // Arbitration
  // ------------------------------------------------------------------------
  assign in_run   = (state_q == S_RUN);
  assign conflict = in_run & bus.wr_req & bus.rd_req;

  // Read wins when alone, under read priority, or when write took the
  // previous conflict; write gets the port whenever read does not.
  assign rd_gnt = in_run & bus.rd_req
                & (~bus.wr_req | RD_PRIO | (last_win_q == WIN_WR));
  assign wr_gnt = in_run & bus.wr_req & ~rd_gnt;

  // ------------------------------------------------------------------------
  // State, sweep counter, round-robin memory and read-valid pipeline
  // ------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop in this block samples the values from before the clock edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= RESET_STATE;
      init_cnt_q  <= '0;
      last_win_q  <= WIN_WR;
      rd_vld_q    <= 1'b0;
      init_done_q <= !INIT_EN;
      busy_q      <= INIT_EN;
    end else begin
      rd_vld_q <= rd_gnt;

      if (state_q == S_INIT) begin
        // The counter is exactly ADDR_WIDTH bits, so it wraps back to zero
        // on the same edge that leaves INIT.
        init_cnt_q <= init_cnt_q + 1'b1;
        if (init_cnt_q == LAST_ADDR) begin
          state_q     <= S_RUN;
          init_done_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      end else begin
        // Only contested cycles move the round-robin pointer.
        if (conflict && !RD_PRIO) begin
          last_win_q <= rd_gnt ? WIN_RD : WIN_WR;
        end
        if (bus.clr_req) begin
          state_q     <= S_INIT;
          init_done_q <= 1'b0;
          busy_q      <= 1'b1;
        end
      end
    end
  end

  // ------------------------------------------------------------------------
  // Macro pin drive
  // ------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first, so no path through
  // the if/else chain can leave a value held and infer a latch.
  always_comb begin
    bus.CEN  = 1'b1;
    bus.GWEN = 1'b1;
    bus.WEN  = '1;
    bus.A    = '0;
    bus.D    = '0;
    if (!in_run) begin
      bus.CEN  = 1'b0;
      bus.GWEN = 1'b0;
      bus.WEN  = '0;
      bus.A    = init_cnt_q;
    end else if (wr_gnt) begin
      bus.CEN  = 1'b0;
      bus.GWEN = 1'b0;
      bus.WEN  = ~bus.wr_bwen;
      bus.A    = bus.wr_addr;
      bus.D    = bus.wr_data;
    end else if (rd_gnt) begin
      bus.CEN  = 1'b0;
      bus.A    = bus.rd_addr;
    end
  end

  // ------------------------------------------------------------------------
  // Requester-facing outputs
  // ------------------------------------------------------------------------
  assign bus.wr_gnt    = wr_gnt;
  assign bus.rd_gnt    = rd_gnt;
  assign bus.rd_vld    = rd_vld_q;
  assign bus.rd_data   = bus.Q;
  assign bus.init_done = init_done_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_ct_spsram_2048x59_arb_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ct_spsram_2048x59_arb_ctrl
//
// Two controllers: a default one (sweep after reset, round-robin) in front of
// a pin-level macro model, and a read-priority one without sweep whose Q is
// tied low. Inputs change 1 time unit after the rising edge; outputs are
// sampled on the falling edge or 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_ct_spsram_2048x59_arb_ctrl;

  localparam int AW    = 11;
  localparam int DW    = 59;
  localparam int DEPTH = 1 << AW;

  localparam logic [DW-1:0] PAT  = 59'h5A5A5A5A5A5A5A5;
  localparam logic [DW-1:0] PART = 59'h7FFFFFF00000000;
  localparam logic [DW-1:0] PAT2 = 59'h0123456789ABCDE;

  logic clk = 1'b0;
  logic rst;
  logic rst_rp;

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  ct_spsram_2048x59_arb_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) rr_if ();
  ct_spsram_2048x59_arb_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) rp_if ();

  ct_spsram_2048x59_arb_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_EN(1'b1), .RD_PRIO(1'b0)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (rr_if.slave)
  );

  ct_spsram_2048x59_arb_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_EN(1'b0), .RD_PRIO(1'b1)
  ) dut_rp (
    .CLK (clk),
    .RST (rst_rp),
    .bus (rp_if.slave)
  );

  // Pin-level macro model: synchronous write with per-bit mask, registered Q
  // that only changes on a read access.
  // NOTE: the array is deliberately not reset; the controller's zero sweep is
  // what gives it defined contents.
  logic [DW-1:0] sram_mem [DEPTH];
  logic [DW-1:0] sram_q;

  always @(posedge clk) begin
    if (!rr_if.CEN) begin
      if (!rr_if.GWEN) sram_mem[rr_if.A] <= (sram_mem[rr_if.A] & rr_if.WEN) | (rr_if.D & ~rr_if.WEN);
      else             sram_q <= sram_mem[rr_if.A];
    end
  end

  assign rr_if.Q = sram_q;
  assign rp_if.Q = '0;

  // Abstract content model: only written words are stored, all else is zero.
  logic [DW-1:0] exp_mem [int];

  function automatic logic [DW-1:0] mem_rd(input int a);
    return exp_mem.exists(a) ? exp_mem[a] : '0;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rr(input logic wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                          input logic [DW-1:0] wb, input logic rd, input logic [AW-1:0] ra,
                          input logic clr);
    rr_if.wr_req  = wr;
    rr_if.wr_addr = wa;
    rr_if.wr_data = wd;
    rr_if.wr_bwen = wb;
    rr_if.rd_req  = rd;
    rr_if.rd_addr = ra;
    rr_if.clr_req = clr;
  endtask

  // Sweep cycles [first, last): macro written with zero at A = cycle index,
  // no grants, busy high.
  task automatic check_sweep(input string tag, input int first, input int last);
    for (int i = first; i < last; i++) begin
      @(negedge clk);
      check($sformatf("%s sweep %0d", tag, i),
            {rr_if.busy, rr_if.init_done, rr_if.CEN, rr_if.GWEN, rr_if.wr_gnt, rr_if.rd_gnt,
             (rr_if.WEN == '0), (rr_if.D == '0), rr_if.A},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, i[AW-1:0]});
    end
  endtask

  // Grant sequence vectors applied right after the first sweep.
  typedef struct packed {
    logic wr_req;
    logic rd_req;
    logic exp_wr_gnt;
    logic exp_rd_gnt;
    logic exp_cen;
    logic exp_gwen;
  } vec_t;

  vec_t vecs [12];

  initial begin
    logic          wr_p, rd_p, last_rd, prev_rg, exp_rg, exp_wg;
    logic [DW-1:0] prev_val, wd, wb;
    logic [AW-1:0] wa, ra;
    logic [63:0]   r64;

    // Round-robin starts with "write won last", so read takes the first tie.
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    rst    = 1'b1;
    rst_rp = 1'b1;
    drive_rr(1'b0, '0, '0, '0, 1'b1, 11'h055, 1'b0);
    rp_if.wr_req  = 1'b0;
    rp_if.wr_addr = 11'h010;
    rp_if.wr_data = 59'h1;
    rp_if.wr_bwen = 59'h3;
    rp_if.rd_req  = 1'b0;
    rp_if.rd_addr = 11'h020;
    rp_if.clr_req = 1'b0;

    // ---- Reset values of both controllers --------------------------------
    @(negedge clk);
    check("rr reset status", {rr_if.busy, rr_if.init_done, rr_if.rd_vld, rr_if.rd_gnt}, 4'b1000);
    check("rr reset pins", {rr_if.CEN, rr_if.GWEN, rr_if.A}, {2'b00, 11'h000});
    check("rp reset status", {rp_if.busy, rp_if.init_done, rp_if.rd_vld}, 3'b010);
    check("rp reset pins", {rp_if.CEN, rp_if.GWEN, (rp_if.WEN == '1)}, 3'b111);

    // ---- Read priority: read wins every tie ------------------------------
    next_cycle();
    rst_rp = 1'b0;
    rp_if.wr_req = 1'b1;
    rp_if.rd_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("rp tie %0d gnt", k), {rp_if.wr_gnt, rp_if.rd_gnt, rp_if.GWEN, rp_if.A},
            {3'b011, 11'h020});
      if (k > 0) check($sformatf("rp tie %0d vld", k), rp_if.rd_vld, 1'b1);
      next_cycle();
    end
    rp_if.rd_req = 1'b0;
    @(negedge clk);
    check("rp lone write", {rp_if.wr_gnt, rp_if.rd_gnt, rp_if.GWEN, rp_if.A}, {3'b100, 11'h010});
    check("rp write mask", {rp_if.WEN, rp_if.D}, {~59'h3, 59'h1});
    next_cycle();
    rp_if.wr_req = 1'b0;
    @(negedge clk);
    check("rp idle", {rp_if.CEN, rp_if.rd_vld, rp_if.wr_gnt}, 3'b100);

    // ---- Test 1: full sweep with a read held pending ---------------------
    next_cycle();
    rst = 1'b0;
    check_sweep("init", 0, DEPTH);
    next_cycle();
    @(negedge clk);
    check("post-init status", {rr_if.init_done, rr_if.busy, rr_if.rd_gnt, rr_if.wr_gnt}, 4'b1010);
    check("post-init read pins", {rr_if.CEN, rr_if.GWEN, rr_if.A}, {2'b01, 11'h055});
    next_cycle();
    rr_if.rd_req = 1'b0;
    @(negedge clk);
    check("post-init read data", {rr_if.rd_vld, rr_if.rd_data}, {1'b1, 59'h0});

    // ---- Grant table (includes the 4-cycle tie: rd, wr, rd, wr) ----------
    for (int v = 0; v < 12; v++) begin
      next_cycle();
      drive_rr(vecs[v].wr_req, 11'h200, '1, '0, vecs[v].rd_req, 11'h123, 1'b0);
      @(negedge clk);
      check($sformatf("vec %0d", v), {rr_if.wr_gnt, rr_if.rd_gnt, rr_if.CEN, rr_if.GWEN},
            {vecs[v].exp_wr_gnt, vecs[v].exp_rd_gnt, vecs[v].exp_cen, vecs[v].exp_gwen});
      if (vecs[v].exp_wr_gnt) check($sformatf("vec %0d zero mask", v), rr_if.WEN, {DW{1'b1}});
    end

    // ---- Test 2: full write, read back, neighbours -----------------------
    next_cycle();
    drive_rr(1'b1, 11'h123, PAT, '1, 1'b0, 11'h000, 1'b0);
    @(negedge clk);
    check("t2 wr pins", {rr_if.wr_gnt, rr_if.rd_gnt, rr_if.CEN, rr_if.GWEN, rr_if.A},
          {4'b1000, 11'h123});
    check("t2 wr D", rr_if.D, PAT);
    check("t2 wr WEN", rr_if.WEN, 59'h0);
    next_cycle();
    drive_rr(1'b0, 11'h123, PAT, '1, 1'b1, 11'h123, 1'b0);
    @(negedge clk);
    check("t2 rd pins", {rr_if.rd_gnt, rr_if.CEN, rr_if.GWEN, rr_if.A}, {3'b101, 11'h123});
    next_cycle();
    rr_if.rd_addr = 11'h124;
    @(negedge clk);
    check("t2 rd 0x123", {rr_if.rd_vld, rr_if.rd_data}, {1'b1, PAT});
    next_cycle();
    rr_if.rd_addr = 11'h200;
    @(negedge clk);
    check("t2 rd 0x124", {rr_if.rd_vld, rr_if.rd_data}, {1'b1, 59'h0});
    next_cycle();
    rr_if.rd_req = 1'b0;
    @(negedge clk);
    check("t2 rd 0x200 no-bit write", {rr_if.rd_vld, rr_if.rd_data}, {1'b1, 59'h0});
    next_cycle();
    @(negedge clk);
    check("t2 vld drop", rr_if.rd_vld, 1'b0);

    // ---- Test 3: partial write ------------------------------------------
    next_cycle();
    drive_rr(1'b1, 11'h300, '1, PART, 1'b0, 11'h300, 1'b0);
    @(negedge clk);
    check("t3 wr WEN", {rr_if.wr_gnt, rr_if.WEN}, {1'b1, ~PART});
    next_cycle();
    drive_rr(1'b0, 11'h300, '1, PART, 1'b1, 11'h300, 1'b0);
    @(negedge clk);
    check("t3 rd gnt", rr_if.rd_gnt, 1'b1);
    next_cycle();
    rr_if.rd_req = 1'b0;
    @(negedge clk);
    check("t3 rd data", {rr_if.rd_vld, rr_if.rd_data}, {1'b1, PART});

    // ---- Test 6: clear together with a read ------------------------------
    next_cycle();
    drive_rr(1'b0, 11'h000, '0, '0, 1'b1, 11'h123, 1'b1);
    @(negedge clk);
    check("t6 clr cycle", {rr_if.rd_gnt, rr_if.init_done, rr_if.busy}, 3'b110);
    next_cycle();
    check("t6 vld in INIT", {rr_if.rd_vld, rr_if.rd_data}, {1'b1, PAT});
    check("t6 status", {rr_if.busy, rr_if.init_done}, 2'b10);
    drive_rr(1'b1, 11'h400, PAT2, '1, 1'b1, 11'h123, 1'b0);
    check_sweep("clr", 0, 600);
    next_cycle();
    rr_if.clr_req = 1'b1;
    check_sweep("clr", 600, 601);
    next_cycle();
    rr_if.clr_req = 1'b0;
    check_sweep("clr", 601, DEPTH);
    next_cycle();
    @(negedge clk);
    // Last tie before the clear went to read, so write takes this one.
    check("t6 first RUN", {rr_if.init_done, rr_if.busy, rr_if.wr_gnt, rr_if.rd_gnt}, 4'b1010);
    next_cycle();
    rr_if.wr_req = 1'b0;
    @(negedge clk);
    check("t6 rd gnt", rr_if.rd_gnt, 1'b1);
    next_cycle();
    rr_if.rd_req = 1'b0;
    @(negedge clk);
    check("t6 cleared data", {rr_if.rd_vld, rr_if.rd_data}, {1'b1, 59'h0});

    // ---- Test 5: reset drops rd_vld, reset mid-sweep restarts it ---------
    next_cycle();
    drive_rr(1'b0, 11'h400, PAT2, '1, 1'b1, 11'h300, 1'b0);
    @(negedge clk);
    check("t5 rd gnt", rr_if.rd_gnt, 1'b1);
    next_cycle();
    check("t5 vld before rst", rr_if.rd_vld, 1'b1);
    rst = 1'b1;
    drive_rr(1'b1, 11'h400, PAT2, '1, 1'b1, 11'h123, 1'b0);
    #1;
    check("t5 rst async", {rr_if.rd_vld, rr_if.busy, rr_if.init_done, rr_if.CEN, rr_if.A},
          {4'b0100, 11'h000});
    next_cycle();
    rst = 1'b0;
    check_sweep("rst1", 0, 1000);
    next_cycle();
    rst = 1'b1;
    #1;
    check("t5 abort", {rr_if.busy, rr_if.rd_gnt, rr_if.wr_gnt, rr_if.A}, {3'b100, 11'h000});
    next_cycle();
    rst = 1'b0;
    check_sweep("rst2", 0, DEPTH);
    next_cycle();
    @(negedge clk);
    check("t5 first RUN tie", {rr_if.init_done, rr_if.wr_gnt, rr_if.rd_gnt}, 3'b101);

    // ---- Randomised traffic against the abstract model -------------------
    exp_mem.delete();
    wr_p     = 1'b1;
    wa       = 11'h400;
    wd       = PAT2;
    wb       = '1;
    rd_p     = 1'b0;
    ra       = 11'h123;
    last_rd  = 1'b1;
    prev_rg  = 1'b1;
    prev_val = '0;
    for (int n = 0; n < 800; n++) begin
      next_cycle();
      if (!wr_p && ($urandom_range(0, 9) < 6)) begin
        wr_p = 1'b1;
        wa   = AW'($urandom_range(0, 15));
        r64  = {$urandom(), $urandom()};
        wd   = r64[DW-1:0];
        case ($urandom_range(0, 3))
          0:       wb = '0;
          1:       wb = '1;
          default: begin
            r64 = {$urandom(), $urandom()};
            wb  = r64[DW-1:0];
          end
        endcase
      end
      if (!rd_p && ($urandom_range(0, 9) < 6)) begin
        rd_p = 1'b1;
        ra   = AW'($urandom_range(0, 15));
      end
      drive_rr(wr_p, wa, wd, wb, rd_p, ra, 1'b0);
      @(negedge clk);

      // Lone request is served; a tie goes to the side that lost the last tie.
      exp_rg = rd_p && (!wr_p || !last_rd);
      exp_wg = wr_p && !exp_rg;
      check($sformatf("rnd %0d gnt", n), {rr_if.wr_gnt, rr_if.rd_gnt}, {exp_wg, exp_rg});
      check($sformatf("rnd %0d vld", n), rr_if.rd_vld, prev_rg);
      if (prev_rg) check($sformatf("rnd %0d data", n), rr_if.rd_data, prev_val);
      if (wr_p && rd_p) last_rd = exp_rg;
      if (exp_wg) begin
        check($sformatf("rnd %0d wr pins", n), {rr_if.CEN, rr_if.GWEN, rr_if.A}, {2'b00, wa});
        exp_mem[int'(wa)] = (mem_rd(int'(wa)) & ~wb) | (wd & wb);
        wr_p = 1'b0;
      end
      if (exp_rg) begin
        check($sformatf("rnd %0d rd pins", n), {rr_if.CEN, rr_if.GWEN, rr_if.A}, {2'b01, ra});
        prev_val = mem_rd(int'(ra));
        rd_p     = 1'b0;
      end
      prev_rg = exp_rg;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ct_spsram_2048x59_arb_ctrl.md
Name: ct_spsram_2048x59_arb_ctrl

Overview:
Access controller for one 2048x59 single-port SRAM macro, with active-low CEN, GWEN and per-bit WEN.
- After reset, and on request, it sweeps the whole array to zero.
- In normal operation it shares the single port between one write requester (refill) and one read requester (lookup), using round-robin or read-priority arbitration.
- Read data returns one cycle after grant.
- It sits directly in front of the macro; requesters never drive the macro pins.

Parameters:
ADDR_WIDTH, 11, SRAM address width; depth = 2^ADDR_WIDTH.
DATA_WIDTH, 59, SRAM data width.
INIT_EN, 1, 1 = run the zero sweep after reset; 0 = enter RUN directly.
RD_PRIO, 0, 0 = round-robin on conflict; 1 = read always wins.

Ports:
CLK  in  1  clock; also drives the SRAM CLK.
RST  in  1  reset, asynchronous, active-high.
wr_req  in  1  write request; held until granted.
wr_addr  in  ADDR_WIDTH  write address.
wr_data  in  DATA_WIDTH  write data.
wr_bwen  in  DATA_WIDTH  per-bit write enable, active-high.
wr_gnt  out  1  write accepted this cycle.
rd_req  in  1  read request; held until granted.
rd_addr  in  ADDR_WIDTH  read address.
rd_gnt  out  1  read accepted this cycle.
rd_vld  out  1  rd_data valid (one cycle after rd_gnt).
rd_data  out  DATA_WIDTH  read data (SRAM Q).
clr_req  in  1  pulse: re-run the zero sweep.
init_done  out  1  high in RUN state.
busy  out  1  high in INIT state.
A  out  ADDR_WIDTH  SRAM address.
CEN  out  1  SRAM chip enable, active-low.
GWEN  out  1  SRAM global write enable, active-low.
WEN  out  DATA_WIDTH  SRAM per-bit write enable, active-low.
D  out  DATA_WIDTH  SRAM write data.

Behaviour:
- States: INIT, RUN. On RST: INIT if INIT_EN=1, else RUN.
- Reset values: init_cnt=0, last_win=write (so read wins the first conflict), rd_vld=0.
- Reset-derived outputs during reset:
  - INIT_EN=1: init_done=0, busy=1, INIT sweep drive on the macro pins.
  - INIT_EN=0: init_done=1, busy=0, idle drive on the macro pins.
- Idle drive: CEN=1, GWEN=1, WEN=all-1, A and D undefined.
- INIT, every cycle:
  - Drive CEN=0, GWEN=0, WEN=0, A=init_cnt, D=0; init_cnt++.
  - wr_gnt=rd_gnt=0; requests stay pending.
  - When init_cnt = 2^ADDR_WIDTH-1 is written, go to RUN next cycle and reset init_cnt to 0.
  - The sweep takes exactly 2^ADDR_WIDTH cycles (2048 by default).
- RUN grants are combinational, in the same cycle as the request.
  - Only one request: it is granted.
  - Both requests: with RD_PRIO=1, read wins. With RD_PRIO=0, the side opposite last_win wins, and last_win updates to the winner. last_win changes only on conflict cycles.
  - Loser sees gnt=0 and must hold its request; no starvation beyond 1 cycle in round-robin mode.
- Write grant: CEN=0, GWEN=0, A=wr_addr, D=wr_data, WEN=~wr_bwen. wr_bwen=0 still consumes the slot, with no bits changed.
- Read grant: CEN=0, GWEN=1, WEN=all-1, A=rd_addr.
- No grant: idle drive.
- rd_vld is a register equal to rd_gnt delayed by 1 cycle. rd_data=Q combinationally; it is meaningful only while rd_vld=1.
- Q remains stable after rd_vld while CEN=1, because the macro holds its address; consumers must not rely on this.
- Write-then-read of the same address in consecutive cycles returns the new data; no bypass is needed.
- clr_req sampled high in RUN:
  - Grants in that same cycle proceed normally.
  - Next cycle enters INIT (init_done=0, busy=1).
  - rd_vld for a read granted in the clr cycle still asserts in the first INIT cycle.
- clr_req in INIT is ignored; the sweep does not restart.
- RST during INIT aborts and restarts the sweep from address 0.
- RST in RUN drops any pending rd_vld.
- Address wrap: init_cnt is ADDR_WIDTH bits and wraps to 0 on exit; requester addresses are used unmodified.

Test Plan:
1. Reset with INIT_EN=1, hold rd_req=1: expect 2048 cycles of CEN=0/GWEN=0/D=0 with A=0..2047, rd_gnt=0 throughout. On cycle 2049, init_done=1 and rd_gnt=1.
2. After init: write addr 0x123 data 0x5A5A5A5A5A5A5A5, bwen all-1, then read 0x123: rd_vld one cycle after rd_gnt with rd_data=0x5A5A5A5A5A5A5A5. Reading 0x124 returns 0.
3. Partial write: bwen=0x7FFFFFF00000000 (bits 58:32) with data all-1 onto a zeroed word, then read: expect 0x7FFFFFF00000000.
4. RD_PRIO=0, wr_req and rd_req both held high for 4 cycles: grants go rd, wr, rd, wr. With RD_PRIO=1: rd granted all 4 cycles, wr_gnt=0.
5. Assert RST at sweep cycle 1000, release: sweep restarts at A=0 and lasts the full 2048 cycles. No grants occur before init_done.
6. clr_req pulse together with a read grant: rd_vld asserts next cycle with the pre-clear value. busy=1 for 2048 cycles. A subsequent read of the same address returns 0.
